tao_exu_ctrl: RTL

- Multi-cycle sequencer for the tao core's execute unit.
- Drives the per-instruction cycle FETCH -> EXEC -> (LSU) -> retire.
- Gates the execute unit's PC register update (pc_wen) and register-file write (rf_wen), and latches the instruction register (ir_wen).
- Halts the core on ebreak or on a bus error/timeout. Turns the single-cycle datapath into one that tolerates variable-latency memories.

---
 rtl/tao_exu_ctrl_pkg.sv | 27 ++
 rtl/gnrl_dffr.sv | 23 ++
 rtl/tao_wdt_cnt.sv | 36 +++
 rtl/tao_exu_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tao_exu_ctrl_pkg.sv
// Shared types for the tao execute-unit sequencer: state encoding and trap causes.
package tao_exu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_F_REQ  = 3'd1,
    ST_F_WAIT = 3'd2,
    ST_EXEC   = 3'd3,
    ST_M_REQ  = 3'd4,
    ST_M_WAIT = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } exu_state_e;

  typedef enum logic [1:0] {
    TRAP_NONE    = 2'd0,
    TRAP_IFETCH  = 2'd1,
    TRAP_LSU     = 2'd2,
    TRAP_TIMEOUT = 2'd3
  } trap_cause_e;

  // States that wait on an external handshake and are therefore watchdog-guarded.
  function automatic logic is_wait_state(input exu_state_e s);
    return (s == ST_F_REQ) || (s == ST_F_WAIT) || (s == ST_M_REQ) || (s == ST_M_WAIT);
  endfunction

endpackage

// File: rtl/gnrl_dffr.sv
// Generic register with synchronous active-low reset to zero.
module gnrl_dffr #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/tao_wdt_cnt.sv
// Handshake watchdog: counts stalled cycles, flags the last allowed one (TIMEOUT-1).
module tao_wdt_cnt #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  gnrl_dffr #(.DW(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .d_i (cnt_d),
    .q_o (cnt_q)
  );

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/tao_exu_ctrl.sv
// Multi-cycle sequencer for the tao execute unit: FETCH -> EXEC -> (LSU) -> retire,
// with sticky HALT (ebreak) and TRAP (bus error / handshake timeout) terminal states.
module tao_exu_ctrl
  import tao_exu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic        ifu_rsp_err,
  output logic        ir_wen,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_ebreak,
  input  logic        dec_rdwen,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  input  logic        lsu_rsp_err,
  output logic        pc_wen,
  output logic        rf_wen,
  output logic        halt,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] inst_cnt,
  output logic [2:0]  state_o
);

  logic [2:0]  state_raw;
  exu_state_e  state_q;
  exu_state_e  state_d;
  logic [1:0]  cause_q;
  logic [1:0]  cause_d;
  logic        halt_q;
  logic        trap_q;
  logic [3:0]  flags_d;
  logic [3:0]  flags_q;
  logic        mem_rd_q;
  logic        mem_rd_d;
  logic [31:0] inst_cnt_q;
  logic [31:0] inst_cnt_d;
  logic        retire;
  logic        exit_evt;
  logic        in_wait;
  logic        wdt_clr;
  logic        wdt_expire;

  assign state_q = exu_state_e'(state_raw);
  assign in_wait = is_wait_state(state_q);

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    mem_rd_d      = mem_rd_q;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    ir_wen        = 1'b0;
    pc_wen        = 1'b0;
    rf_wen        = 1'b0;
    retire        = 1'b0;
    exit_evt      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_F_REQ;
      end
      ST_F_REQ: begin
        ifu_req_valid = 1'b1;
        exit_evt      = ifu_req_ready;
        if (ifu_req_ready) begin
          state_d = ST_F_WAIT;
        end
      end
      ST_F_WAIT: begin
        exit_evt = ifu_rsp_valid;
        if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            state_d = ST_TRAP;
            cause_d = TRAP_IFETCH;
          end else begin
            ir_wen  = 1'b1;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (dec_ebreak) begin
          retire  = 1'b1;
          state_d = ST_HALT;
        end else if (dec_is_load || dec_is_store) begin
          // Decoder outputs are only trusted in EXEC, so the load write-back decision is kept.
          mem_rd_d = dec_is_load & dec_rdwen;
          state_d  = ST_M_REQ;
        end else begin
          pc_wen  = 1'b1;
          rf_wen  = dec_rdwen;
          retire  = 1'b1;
          state_d = ST_F_REQ;
        end
      end
      ST_M_REQ: begin
        lsu_req_valid = 1'b1;
        exit_evt      = lsu_req_ready;
        if (lsu_req_ready) begin
          state_d = ST_M_WAIT;
        end
      end
      ST_M_WAIT: begin
        exit_evt = lsu_rsp_valid;
        if (lsu_rsp_valid) begin
          if (lsu_rsp_err) begin
            state_d = ST_TRAP;
            cause_d = TRAP_LSU;
          end else begin
            pc_wen  = 1'b1;
            rf_wen  = mem_rd_q;
            retire  = 1'b1;
            state_d = ST_F_REQ;
          end
        end
      end
      ST_HALT, ST_TRAP: begin
        state_d = state_q;
      end
    endcase

    // A handshake completing on the last allowed cycle takes precedence over the timeout.
    if (in_wait && wdt_expire && !exit_evt) begin
      state_d = ST_TRAP;
      cause_d = TRAP_TIMEOUT;
    end

    // Nothing leaves the block while reset is held, even if the old state was mid-transaction.
    if (!rst) begin
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      ir_wen        = 1'b0;
      pc_wen        = 1'b0;
      rf_wen        = 1'b0;
    end
  end

  assign wdt_clr    = (state_d != state_q);
  assign inst_cnt_d = inst_cnt_q + 32'(retire);
  assign flags_d    = {(state_d == ST_HALT) || (state_d == ST_TRAP), state_d == ST_TRAP, cause_d};
  assign halt_q     = flags_q[3];
  assign trap_q     = flags_q[2];
  assign cause_q    = flags_q[1:0];

  gnrl_dffr #(.DW(3)) u_state (
    .clk (clk),
    .rst (rst),
    .d_i (state_d),
    .q_o (state_raw)
  );

  gnrl_dffr #(.DW(4)) u_flags (
    .clk (clk),
    .rst (rst),
    .d_i (flags_d),
    .q_o (flags_q)
  );

  gnrl_dffr #(.DW(1)) u_mem_rd (
    .clk (clk),
    .rst (rst),
    .d_i (mem_rd_d),
    .q_o (mem_rd_q)
  );

  gnrl_dffr #(.DW(32)) u_inst_cnt (
    .clk (clk),
    .rst (rst),
    .d_i (inst_cnt_d),
    .q_o (inst_cnt_q)
  );

  tao_wdt_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wdt_clr),
    .en_i     (in_wait),
    .expire_o (wdt_expire)
  );

  assign halt       = halt_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign inst_cnt   = inst_cnt_q;
  assign state_o    = state_raw;

endmodule
